// File: rtl/fir_pkg.sv
`default_nettype none
// fir_pkg: width helpers, saturation and shared types for the symmetric FIR datapath.
// Rev 1.0
package fir_pkg;

    localparam int SAT_W      = 64;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_NTAPS  = 9;

    function automatic int prod_w(input int dw, input int cw);
        return dw + cw + 1;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int m);
        return prod_w(dw, cw) + $clog2(m);
    endfunction

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;
    typedef logic signed [acc_w(DEF_DATA_W, DEF_COEF_W, (DEF_NTAPS+1)/2)-1:0] acc_t;

    // Largest/smallest representable value of a dw-bit signed word, widened to SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_hi(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_lo(input int dw);
        return -sat_hi(dw) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                          input int dw);
        if (v > sat_hi(dw)) begin
            return sat_hi(dw);
        end else if (v < sat_lo(dw)) begin
            return sat_lo(dw);
        end
        return v;
    endfunction

    function automatic logic sat_clipped(input logic signed [SAT_W-1:0] v, input int dw);
        return (v > sat_hi(dw)) || (v < sat_lo(dw));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_add.sv
`default_nettype none
// fir_add: two-input signed adder; the single point where the filter performs addition.
// Rev 1.0
module fir_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule
`default_nettype wire

// File: rtl/fir_sym_stream.sv
`default_nettype none
// fir_sym_stream: streaming symmetric FIR with pre-add folding, loadable taps, scaling and saturation.
// Rev 1.0
module fir_sym_stream
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 9,
    parameter int OUT_SHIFT = 0
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic                               in_valid,
    input  logic signed [DATA_W-1:0]           x,
    input  logic                               flush,
    input  logic                               coef_we,
    input  logic [$clog2((NTAPS+1)/2)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]           coef_data,
    output logic                               out_valid,
    output logic signed [DATA_W-1:0]           y,
    output logic                               sat
);

    localparam int M      = (NTAPS + 1) / 2;
    localparam int PAW    = DATA_W + 1;
    localparam int PW     = prod_w(DATA_W, COEF_W);
    localparam int AW     = acc_w(DATA_W, COEF_W, M);
    localparam int LEAVES = 1 << $clog2(M);

    logic signed [DATA_W-1:0] d_q [NTAPS];
    logic signed [DATA_W-1:0] d_d [NTAPS];
    logic signed [COEF_W-1:0] c_q [M];
    logic signed [PAW-1:0]    p_d [M];
    logic signed [PAW-1:0]    p_q [M];
    logic signed [PW-1:0]     m_d [M];
    logic signed [PW-1:0]     m_q [M];
    logic signed [AW-1:0]     acc_node [2*LEAVES-1];
    logic signed [AW-1:0]     acc_shift;
    logic signed [DATA_W-1:0] y_d;
    logic                     sat_d;
    logic signed [DATA_W-1:0] y_q;
    logic                     sat_q;
    logic [3:0]               vld_q;

    // Flush and a valid sample on the same edge leave only the new sample in the line.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            d_d[k] = d_q[k];
        end
        if (in_valid) begin
            d_d[0] = x;
            for (int k = 1; k < NTAPS; k++) begin
                d_d[k] = flush ? '0 : d_q[k-1];
            end
        end else if (flush) begin
            for (int k = 0; k < NTAPS; k++) begin
                d_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < NTAPS; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < M; k++) begin
                c_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < M; k++) begin
                if (coef_we && (int'(coef_addr) == k)) begin
                    c_q[k] <= coef_data;
                end
            end
        end
    end

    for (genvar k = 0; k < M - 1; k++) begin : g_preadd
        fir_add #(.W(PAW)) u_preadd (
            .a_i   (PAW'(d_q[k])),
            .b_i   (PAW'(d_q[NTAPS-1-k])),
            .sum_o (p_d[k])
        );
    end
    assign p_d[M-1] = PAW'(d_q[M-1]);

    always_comb begin
        for (int k = 0; k < M; k++) begin
            m_d[k] = PW'(p_q[k]) * PW'(c_q[k]);
        end
    end

    // Products fill the leaves of a power-of-two tree; unused leaves are tied to zero.
    for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
        if (j < M) begin : g_prod
            assign acc_node[LEAVES-1+j] = AW'(m_q[j]);
        end else begin : g_pad
            assign acc_node[LEAVES-1+j] = '0;
        end
    end

    for (genvar i = 0; i < LEAVES - 1; i++) begin : g_tree
        fir_add #(.W(AW)) u_tree (
            .a_i   (acc_node[2*i+1]),
            .b_i   (acc_node[2*i+2]),
            .sum_o (acc_node[i])
        );
    end

    assign acc_shift = acc_node[0] >>> OUT_SHIFT;
    assign y_d       = DATA_W'(saturate(SAT_W'(acc_shift), DATA_W));
    assign sat_d     = sat_clipped(SAT_W'(acc_shift), DATA_W);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < M; k++) begin
                p_q[k] <= '0;
                m_q[k] <= '0;
            end
            vld_q <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            for (int k = 0; k < M; k++) begin
                p_q[k] <= p_d[k];
                m_q[k] <= m_d[k];
            end
            vld_q <= {vld_q[2:0], in_valid};
            if (vld_q[2]) begin
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    assign out_valid = vld_q[3];
    assign y         = y_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_sym_stream.sv
`default_nettype none
// tb_fir_sym_stream: directed and random stimulus against an equation-level filter model.
// Rev 1.0
module tb_fir_sym_stream;

    localparam int NT       = 9;
    localparam int NC       = (NT + 1) / 2;
    localparam int TB_SHIFT = 0;

    logic               clk = 1'b0;
    logic               rstN;
    logic               in_valid;
    logic signed [15:0] x;
    logic               flush;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               out_valid;
    logic signed [15:0] y;
    logic               sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_sym_stream #(
        .DATA_W    (16),
        .COEF_W    (16),
        .NTAPS     (NT),
        .OUT_SHIFT (TB_SHIFT)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (in_valid),
        .x         (x),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y         (y),
        .sat       (sat)
    );

    // Model: accepted-sample history, coefficient table, and results in flight.
    longint hist [NT];
    longint cm   [NC];
    logic   s_v  [2];
    longint s_h  [2][NT];
    logic   pend_v;
    longint pend_y;
    logic   pend_s;
    logic   m_ov;
    longint m_y;
    logic   m_sat;

    int   cap_y [$];
    logic cap_s [$];

    int imp   [10] = '{2, 0, 6, 18, -32, 18, 6, 0, 2, 0};
    int imp64 [10] = '{2, 0, 6, 18, 64, 18, 6, 0, 2, 0};

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            hist[k]   = 0;
            s_h[0][k] = 0;
            s_h[1][k] = 0;
        end
        for (int k = 0; k < NC; k++) cm[k] = 0;
        s_v[0] = 1'b0; s_v[1] = 1'b0;
        pend_v = 1'b0; pend_y = 0; pend_s = 1'b0;
        m_ov = 1'b0;   m_y = 0;    m_sat = 1'b0;
    endtask

    // A sample's output uses the coefficients in force two edges after acceptance.
    task automatic model_edge();
        longint acc;
        int     idx;
        m_ov = pend_v;
        if (pend_v) begin
            m_y   = pend_y;
            m_sat = pend_s;
        end
        acc = 0;
        for (int k = 0; k < NT; k++) begin
            idx = (k < NT - 1 - k) ? k : NT - 1 - k;
            acc += cm[idx] * s_h[1][k];
        end
        acc = acc >>> TB_SHIFT;
        if (acc > 32767) begin
            pend_y = 32767;  pend_s = 1'b1;
        end else if (acc < -32768) begin
            pend_y = -32768; pend_s = 1'b1;
        end else begin
            pend_y = acc;    pend_s = 1'b0;
        end
        pend_v = s_v[1];
        if (coef_we && (int'(coef_addr) < NC)) cm[coef_addr] = coef_data;
        if (flush) for (int k = 0; k < NT; k++) hist[k] = 0;
        if (in_valid) begin
            for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
        end
        s_v[1] = s_v[0];
        s_v[0] = in_valid;
        for (int k = 0; k < NT; k++) begin
            s_h[1][k] = s_h[0][k];
            s_h[0][k] = hist[k];
        end
    endtask

    task automatic drive(input logic v, input logic signed [15:0] xv, input logic fl,
                         input logic we, input logic [2:0] a, input logic signed [15:0] cd);
        in_valid  = v;
        x         = xv;
        flush     = fl;
        coef_we   = we;
        coef_addr = a;
        coef_data = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("y", 64'(y), m_y);
        check("sat", 64'(sat), 64'(m_sat));
        if (out_valid === 1'b1) begin
            cap_y.push_back(int'(y));
            cap_s.push_back(sat);
        end
    endtask

    task automatic step(input logic v, input logic signed [15:0] xv);
        drive(v, xv, 1'b0, 1'b0, 3'd0, 16'sd0);
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic signed [15:0] cd);
        drive(1'b0, 16'sd0, 1'b0, 1'b1, a, cd);
        tick();
    endtask

    task automatic load_base();
        wr(3'd0, 16'sd2);
        wr(3'd1, 16'sd0);
        wr(3'd2, 16'sd6);
        wr(3'd3, 16'sd18);
        wr(3'd4, -16'sd32);
    endtask

    task automatic check_seq(input string tag, input int scale, input logic use64, input int n);
        check($sformatf("%s_count", tag), 64'(cap_y.size()), 64'(n));
        for (int i = 0; i < 10 && i < cap_y.size(); i++) begin
            check($sformatf("%s_y%0d", tag, i), 64'(cap_y[i]),
                  64'(scale * (use64 ? imp64[i] : imp[i])));
            check($sformatf("%s_sat%0d", tag, i), 64'(cap_s[i]), 64'd0);
        end
    endtask

    function automatic logic signed [15:0] rnd_x();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return 16'(int'($urandom_range(0, 200)) - 100);
    endfunction

    initial begin
        rstN = 1'b0;
        drive(1'b0, 16'sd0, 1'b0, 1'b0, 3'd0, 16'sd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        rstN = 1'b1;

        load_base();
        wr(3'd7, 16'sd999);

        // Impulse response
        cap_y.delete(); cap_s.delete();
        step(1'b1, 16'sd1);
        repeat (12) step(1'b1, 16'sd0);
        repeat (4) step(1'b0, 16'sd0);
        check_seq("impulse", 1, 1'b0, 13);

        // Impulse with samples every third cycle
        cap_y.delete(); cap_s.delete();
        step(1'b1, 16'sd1);
        repeat (12) begin
            step(1'b0, 16'sd0);
            step(1'b0, 16'sd0);
            step(1'b1, 16'sd0);
        end
        repeat (4) step(1'b0, 16'sd0);
        check_seq("gapped", 1, 1'b0, 13);

        // Step response settles at 100 * sum(h) = 2000
        cap_y.delete(); cap_s.delete();
        repeat (14) step(1'b1, 16'sd100);
        repeat (4) step(1'b0, 16'sd0);
        check("step_count", 64'(cap_y.size()), 64'd14);
        if (cap_y.size() == 14) begin
            check("step_y8", 64'(cap_y[8]), 64'd2000);
            check("step_y13", 64'(cap_y[13]), 64'd2000);
        end

        // Saturation at both rails
        wr(3'd0, 16'sd0); wr(3'd1, 16'sd0); wr(3'd2, 16'sd0); wr(3'd3, 16'sd0);
        wr(3'd4, 16'sd1000);
        cap_y.delete(); cap_s.delete();
        repeat (10) step(1'b1, 16'sd1000);
        repeat (4) step(1'b0, 16'sd0);
        check("satpos_y", 64'(cap_y[$]), 64'd32767);
        check("satpos_sat", 64'(cap_s[$]), 64'd1);
        cap_y.delete(); cap_s.delete();
        repeat (10) step(1'b1, -16'sd1000);
        repeat (4) step(1'b0, 16'sd0);
        check("satneg_y", 64'(cap_y[$]), -64'sd32768);
        check("satneg_sat", 64'(cap_s[$]), 64'd1);

        // Random traffic with coefficient writes and flushes
        load_base();
        repeat (80) begin
            drive(($urandom_range(0, 3) != 0), rnd_x(), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                  16'(int'($urandom_range(0, 511)) - 256));
            tick();
        end

        // Mid-stream coefficient update alongside valid samples; ignored address 7
        load_base();
        repeat (4) step(1'b1, rnd_x());
        drive(1'b1, 16'sd7, 1'b0, 1'b1, 3'd4, 16'sd64);
        tick();
        repeat (3) step(1'b1, rnd_x());
        drive(1'b1, 16'sd9, 1'b0, 1'b1, 3'd7, -16'sd5);
        tick();
        repeat (3) step(1'b1, rnd_x());
        repeat (4) step(1'b0, 16'sd0);

        // Flush together with a valid sample of 5
        cap_y.delete(); cap_s.delete();
        drive(1'b1, 16'sd5, 1'b1, 1'b0, 3'd0, 16'sd0);
        tick();
        repeat (9) step(1'b1, 16'sd0);
        repeat (4) step(1'b0, 16'sd0);
        check_seq("flush", 5, 1'b1, 10);

        // Asynchronous reset in the middle of a stream
        repeat (6) step(1'b1, rnd_x());
        drive(1'b1, 16'sd123, 1'b0, 1'b0, 3'd0, 16'sd0);
        #3 rstN = 1'b0;
        #1;
        model_reset();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_y", 64'(y), 64'd0);
        check("arst_sat", 64'(sat), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_out_valid", 64'(out_valid), 64'd0);
        rstN = 1'b1;
        cap_y.delete(); cap_s.delete();
        repeat (8) step(1'b1, rnd_x());
        repeat (4) step(1'b0, 16'sd0);
        check("post_rst_count", 64'(cap_y.size()), 64'd8);
        foreach (cap_y[i]) check($sformatf("post_rst_y%0d", i), 64'(cap_y[i]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
